// File: rtl/proc_ctrl_pkg.sv
// Shared constants for the 16-bit multicycle processor control path:
// FSM state codes, opcode map, funcfield shift selectors and ALU operation codes.
package proc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_ALU_WB   = 4'd4;
    localparam logic [3:0] S_BRANCH   = 4'd5;
    localparam logic [3:0] S_JUMP     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [3:0] OP_SHIFT = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_J     = 4'b0011;
    localparam logic [3:0] OP_BE    = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_SHLI  = 4'b0110;
    localparam logic [3:0] OP_SHRI  = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_ORI   = 4'b1010;
    localparam logic [3:0] OP_SUB   = 4'b1011;
    localparam logic [3:0] OP_NAND  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_NANDI = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1111;

    localparam logic [3:0] FN_SHL = 4'd1;
    localparam logic [3:0] FN_SHR = 4'd2;
    localparam logic [3:0] FN_SAR = 4'd3;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_NAND = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SHL  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_SAR  = 3'd6;

    function automatic logic is_shift_func(input logic [3:0] fn);
        return (fn == FN_SHL) || (fn == FN_SHR) || (fn == FN_SAR);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational map from IR opcode/funcfield to the ALU operation used in
// the execute stage; unknown shift selectors fall back to ADD.
import proc_ctrl_pkg::*;

module alu_op_decoder (
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_funcfield,
    output logic [2:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_opcode)
            OP_ADD, OP_ADDI:   o_alu_op = ALU_ADD;
            OP_SUB, OP_SUBI:   o_alu_op = ALU_SUB;
            OP_NAND, OP_NANDI: o_alu_op = ALU_NAND;
            OP_OR, OP_ORI:     o_alu_op = ALU_OR;
            OP_SHLI:           o_alu_op = ALU_SHL;
            OP_SHRI:           o_alu_op = ALU_SHR;
            OP_SHIFT: begin
                case (i_funcfield)
                    FN_SHL:  o_alu_op = ALU_SHL;
                    FN_SHR:  o_alu_op = ALU_SHR;
                    FN_SAR:  o_alu_op = ALU_SAR;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default:           o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM with memory wait states and a retired-instruction counter.
// Define CTRL_TRAP_EN to send undefined shift encodings to a sticky TRAP state.
import proc_ctrl_pkg::*;

module multicycle_control_fsm #(
    parameter int IRET_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic [3:0]        funcfield,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic [3:0]        state,
    output logic [IRET_W-1:0] iret_cnt
);

`ifdef CTRL_TRAP_EN
    localparam logic [3:0] BADOP_NEXT     = S_TRAP;
    localparam logic       BADOP_RETIRES  = 1'b0;
`else
    localparam logic [3:0] BADOP_NEXT     = S_FETCH;
    localparam logic       BADOP_RETIRES  = 1'b1;
`endif

    logic [3:0]        r_state;
    logic [IRET_W-1:0] r_iret;
    logic [3:0]        w_next;
    logic              w_bad_op;
    logic              w_retire;
    logic [2:0]        w_exec_alu_op;

    alu_op_decoder u_alu_op_decoder (
        .i_opcode    (opcode),
        .i_funcfield (funcfield),
        .o_alu_op    (w_exec_alu_op)
    );

    assign w_bad_op = (opcode == OP_SHIFT) && !is_shift_func(funcfield);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAND, OP_OR:  w_next = S_EXEC_R;
                    OP_SHIFT:  w_next = w_bad_op ? BADOP_NEXT : S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_SUBI, OP_NANDI,
                    OP_SHLI, OP_SHRI:                w_next = S_EXEC_I;
                    OP_BE, OP_BNE:                   w_next = S_BRANCH;
                    OP_J:                            w_next = S_JUMP;
                    OP_LW, OP_SW:                    w_next = S_MEM_ADDR;
                    default:                         w_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I:  w_next = S_ALU_WB;
            S_ALU_WB, S_BRANCH, S_JUMP, S_MEM_WB: w_next = S_FETCH;
            S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    assign w_retire = (r_state == S_ALU_WB) || (r_state == S_BRANCH) ||
                      (r_state == S_JUMP)   || (r_state == S_MEM_WB) ||
                      ((r_state == S_MEM_WR) && mem_ready) ||
                      ((r_state == S_DECODE) && w_bad_op && BADOP_RETIRES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_iret  <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_iret <= r_iret + {{(IRET_W-1){1'b0}}, 1'b1};
        end
    end

    // Everything is forced low during reset, including the debug state and count.
    assign state    = rst ? 4'd0 : r_state;
    assign iret_cnt = rst ? '0 : r_iret;

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    alu_src_b = 2'd1;
                end
                S_DECODE:   alu_src_b = 2'd2;
                S_EXEC_R:   alu_op = w_exec_alu_op;
                S_EXEC_I: begin
                    alu_op    = w_exec_alu_op;
                    alu_src_b = ((opcode == OP_ADDI) || (opcode == OP_SUBI)) ? 2'd2 : 2'd3;
                end
                S_ALU_WB:   reg_write = 1'b1;
                S_BRANCH: begin
                    pc_src   = 2'd1;
                    alu_op   = ALU_SUB;
                    pc_write = (opcode == OP_BE) ? zero : ~zero;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
                S_MEM_ADDR: alu_src_b = 2'd2;
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: instructions are expanded into per-cycle expectation plans
// (state, inputs, strobes) and every cycle of the DUT is compared against them.
module tb_multicycle_control_fsm;

    localparam int IW   = 4;
    localparam int WRAP = 1 << IW;
`ifdef CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, ALU_WB = 4, BRANCH = 5;
    localparam int JUMP = 6, MEM_ADDR = 7, MEM_RD = 8, MEM_WB = 9, MEM_WR = 10, TRAP = 11;
    localparam int C_R = 0, C_I = 1, C_BR = 2, C_J = 3, C_LW = 4, C_SW = 5, C_NOP = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    opcode, funcfield;
    logic          zero, mem_ready;
    logic          ir_write, pc_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic [IW-1:0] iret_cnt;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.IRET_W(IW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funcfield(funcfield), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .iret_cnt(iret_cnt)
    );

    typedef struct {
        int       st;
        bit       rdy;
        bit [3:0] opc;
        bit [3:0] fn;
        bit       zr;
        bit       ret;
    } step_t;

    step_t plan[$];
    int    n_chk = 0, n_pass = 0;
    int    model_cnt = 0;
    int    obs_cycles, obs_irw, obs_regw, obs_rd_hold, obs_br_pcw;
    int    obs_st[$];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    endtask

    function automatic int cls(bit [3:0] o, bit [3:0] f);
        case (o)
            4'd8, 4'd11, 4'd12, 4'd15:              return C_R;
            4'd9, 4'd10, 4'd13, 4'd14, 4'd6, 4'd7:  return C_I;
            4'd4, 4'd5:                             return C_BR;
            4'd3:                                   return C_J;
            4'd1:                                   return C_LW;
            4'd2:                                   return C_SW;
            default:                                return (f >= 1 && f <= 3) ? C_R : C_NOP;
        endcase
    endfunction

    // ALU op per instruction: add/addi, sub/subi, nand/nandi, or/ori, shifts.
    function automatic int alu_of(bit [3:0] o, bit [3:0] f);
        case (o)
            4'd8, 4'd9:   return 0;
            4'd11, 4'd13: return 1;
            4'd12, 4'd14: return 2;
            4'd15, 4'd10: return 3;
            4'd6:         return 4;
            4'd7:         return 5;
            default:      return (f == 1) ? 4 : (f == 2) ? 5 : 6;
        endcase
    endfunction

    function automatic step_t mk(int st, bit rdy, bit [3:0] o, bit [3:0] f, bit zr, bit ret);
        step_t s;
        s.st = st; s.rdy = rdy; s.opc = o; s.fn = f; s.zr = zr; s.ret = ret;
        return s;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic add_instr(bit [3:0] o, bit [3:0] f, bit zr, int fw, int mw);
        int c;
        c = cls(o, f);
        for (int i = 0; i < fw; i++) plan.push_back(mk(FETCH, 1'b0, 4'($urandom), 4'($urandom), rb(), 1'b0));
        plan.push_back(mk(FETCH, 1'b1, 4'($urandom), 4'($urandom), rb(), 1'b0));
        plan.push_back(mk(DECODE, rb(), o, f, rb(), (c == C_NOP) && !TRAP_EN));
        case (c)
            C_R: begin
                plan.push_back(mk(EXEC_R, rb(), o, f, rb(), 1'b0));
                plan.push_back(mk(ALU_WB, rb(), o, f, rb(), 1'b1));
            end
            C_I: begin
                plan.push_back(mk(EXEC_I, rb(), o, f, rb(), 1'b0));
                plan.push_back(mk(ALU_WB, rb(), o, f, rb(), 1'b1));
            end
            C_BR: plan.push_back(mk(BRANCH, rb(), o, f, zr, 1'b1));
            C_J:  plan.push_back(mk(JUMP, rb(), o, f, rb(), 1'b1));
            C_LW: begin
                plan.push_back(mk(MEM_ADDR, rb(), o, f, rb(), 1'b0));
                for (int i = 0; i < mw; i++) plan.push_back(mk(MEM_RD, 1'b0, o, f, rb(), 1'b0));
                plan.push_back(mk(MEM_RD, 1'b1, o, f, rb(), 1'b0));
                plan.push_back(mk(MEM_WB, rb(), o, f, rb(), 1'b1));
            end
            C_SW: begin
                plan.push_back(mk(MEM_ADDR, rb(), o, f, rb(), 1'b0));
                for (int i = 0; i < mw; i++) plan.push_back(mk(MEM_WR, 1'b0, o, f, rb(), 1'b0));
                plan.push_back(mk(MEM_WR, 1'b1, o, f, rb(), 1'b1));
            end
            default: if (TRAP_EN) for (int i = 0; i < 4; i++) plan.push_back(mk(TRAP, rb(), o, f, rb(), 1'b0));
        endcase
    endtask

    task automatic check_step(step_t s);
        int fr;
        fr = (s.st == FETCH && s.rdy) ? 1 : 0;
        chk("state", int'(state), s.st);
        chk("ir_write", int'(ir_write), fr);
        chk("pc_write", int'(pc_write), fr | int'(s.st == JUMP) |
            ((s.st == BRANCH) ? ((s.opc == 4'd4) ? int'(s.zr) : int'(!s.zr)) : 0));
        chk("mem_read", int'(mem_read), int'(s.st == FETCH || s.st == MEM_RD));
        chk("mem_write", int'(mem_write), int'(s.st == MEM_WR));
        chk("reg_write", int'(reg_write), int'(s.st == ALU_WB || s.st == MEM_WB));
        chk("iret_cnt", int'(iret_cnt), model_cnt % WRAP);
        if (s.st == FETCH) chk("i_or_d", int'(i_or_d), 0);
        if (s.st == MEM_RD || s.st == MEM_WR) chk("i_or_d", int'(i_or_d), 1);
        if (s.st == ALU_WB || s.st == MEM_WB) chk("mem_to_reg", int'(mem_to_reg), int'(s.st == MEM_WB));
        if (fr == 1)         chk("pc_src", int'(pc_src), 0);
        if (s.st == BRANCH)  chk("pc_src", int'(pc_src), 1);
        if (s.st == JUMP)    chk("pc_src", int'(pc_src), 2);
        if (fr == 1)         chk("alu_src_b", int'(alu_src_b), 1);
        if (s.st == DECODE || s.st == MEM_ADDR) chk("alu_src_b", int'(alu_src_b), 2);
        if (s.st == EXEC_R)  chk("alu_src_b", int'(alu_src_b), 0);
        if (s.st == EXEC_I)  chk("alu_src_b", int'(alu_src_b), (s.opc == 4'd9 || s.opc == 4'd13) ? 2 : 3);
        if (fr == 1 || s.st == DECODE || s.st == MEM_ADDR) chk("alu_op", int'(alu_op), 0);
        if (s.st == EXEC_R || s.st == EXEC_I) chk("alu_op", int'(alu_op), alu_of(s.opc, s.fn));
        if (s.st == BRANCH)  chk("alu_op", int'(alu_op), 1);
        obs_cycles++;
        obs_st.push_back(int'(state));
        if (ir_write)  obs_irw++;
        if (reg_write) obs_regw++;
        if (state == 4'd8 && mem_read) obs_rd_hold++;
        if (state == 4'd5) obs_br_pcw = int'(pc_write);
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            rst = 1'b0; opcode = s.opc; funcfield = s.fn; zero = s.zr; mem_ready = s.rdy;
            #3;
            check_step(s);
            @(posedge clk); #1;
            if (s.ret) model_cnt++;
        end
    endtask

    task automatic reset_cycle();
        rst = 1'b1; opcode = 4'($urandom); funcfield = 4'($urandom); zero = rb(); mem_ready = rb();
        #3;
        chk("rst_strobes", int'({ir_write, pc_write, mem_read, mem_write, reg_write}), 0);
        chk("rst_others", int'({pc_src, i_or_d, mem_to_reg, alu_src_b, alu_op}), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_iret", int'(iret_cnt), 0);
        @(posedge clk); #1;
        model_cnt = 0;
        plan.delete();
    endtask

    task automatic clear_obs();
        obs_cycles = 0; obs_irw = 0; obs_regw = 0; obs_rd_hold = 0; obs_br_pcw = -1;
        obs_st.delete();
    endtask

    initial begin
        int exp_add[4] = '{0, 1, 2, 4};
        int prev, k;
        bit [3:0] o, f;

        reset_cycle();
        reset_cycle();

        // add 0x8B48, no waits
        clear_obs();
        add_instr(4'h8, 4'h8, 1'b0, 0, 0);
        run_plan();
        chk("add_cycles", obs_cycles, 4);
        for (int i = 0; i < 4; i++) chk("add_seq", obs_st[i], exp_add[i]);
        chk("add_ir_pulses", obs_irw, 1);
        chk("add_regw_pulses", obs_regw, 1);
        chk("add_back_fetch", int'(state), 0);
        chk("add_iret", int'(iret_cnt), 1);

        // lw 0x1BC9 with two wait cycles in MEM_RD
        clear_obs();
        add_instr(4'h1, 4'h9, 1'b0, 0, 2);
        run_plan();
        chk("lw_cycles", obs_cycles, 7);
        chk("lw_memrd_hold", obs_rd_hold, 3);
        chk("lw_regw_pulses", obs_regw, 1);
        chk("lw_iret", int'(iret_cnt), 2);

        // be / bne with zero=1
        clear_obs();
        add_instr(4'h4, 4'h8, 1'b1, 0, 0);
        run_plan();
        chk("be_taken_pcw", obs_br_pcw, 1);
        clear_obs();
        add_instr(4'h5, 4'h8, 1'b1, 0, 0);
        run_plan();
        chk("bne_not_taken_pcw", obs_br_pcw, 0);
        chk("br_iret", int'(iret_cnt), 4);

        // sw 0x2BC9 with one wait cycle
        clear_obs();
        add_instr(4'h2, 4'h9, 1'b0, 0, 1);
        run_plan();
        chk("sw_cycles", obs_cycles, 5);
        chk("sw_regw_pulses", obs_regw, 0);
        chk("sw_iret", int'(iret_cnt), 5);

        // reset in the middle of a stalled load
        plan.push_back(mk(FETCH, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0));
        plan.push_back(mk(DECODE, 1'b0, 4'h1, 4'h9, 1'b0, 1'b0));
        plan.push_back(mk(MEM_ADDR, 1'b0, 4'h1, 4'h9, 1'b0, 1'b0));
        plan.push_back(mk(MEM_RD, 1'b0, 4'h1, 4'h9, 1'b0, 1'b0));
        run_plan();
        reset_cycle();
        add_instr(4'h8, 4'h1, 1'b0, 1, 0);
        run_plan();
        chk("post_rst_iret", int'(iret_cnt), 1);

        // randomized instruction stream, with occasional truncated instructions + reset
        for (int n = 0; n < 300; n++) begin
            o = 4'($urandom);
            f = 4'($urandom);
            if (TRAP_EN && o == 4'h0 && !(f >= 1 && f <= 3)) f = 4'd3;
            add_instr(o, f, rb(), $urandom_range(2, 0), $urandom_range(3, 0));
            if ($urandom_range(39, 0) == 0) begin
                k = $urandom_range(plan.size() - 1, 1);
                while (plan.size() > k) void'(plan.pop_back());
                run_plan();
                reset_cycle();
            end else begin
                run_plan();
            end
        end

        // undefined shift selector 0000/0111
        prev = model_cnt;
        add_instr(4'h0, 4'h7, 1'b0, 0, 0);
        run_plan();
`ifdef CTRL_TRAP_EN
        chk("trap_held", int'(state), 11);
        chk("trap_iret", int'(iret_cnt), prev % WRAP);
        reset_cycle();
`else
        chk("nop_back_fetch", int'(state), 0);
        chk("nop_iret", int'(iret_cnt), (prev + 1) % WRAP);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
